// File: rtl/vdp_init_sequencer.sv
// Table-driven VDP initialiser: fetches 16-bit commands from a synchronous table
// and issues write-only transfers on a 4-phase req/ack bus.
module vdp_init_sequencer #(
  parameter int TABLE_AW    = 6,
  parameter int WAIT_SHIFT  = 4,
  parameter int ACK_TIMEOUT = 1023,
  parameter bit RERUN       = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                sdram_busy,
  output logic [TABLE_AW-1:0] tbl_addr,
  input  logic [15:0]         tbl_data,
  output logic                req,
  input  logic                ack,
  output logic                wr,
  output logic [1:0]          address,
  output logic [7:0]          wdata,
  output logic                busy,
  output logic                done,
  output logic                error
);

  typedef enum logic [3:0] {
    S_INIT_WAIT,
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_REQ,
    S_ACK_HI,
    S_ACK_LO,
    S_WAITCNT,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [1:0] OP_END  = 2'd0;
  localparam logic [1:0] OP_REG  = 2'd1;
  localparam logic [1:0] OP_PORT = 2'd2;
  localparam logic [1:0] OP_WAIT = 2'd3;

  localparam int TO_W = $clog2(ACK_TIMEOUT + 2);
  localparam int WC_W = 8 + WAIT_SHIFT;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  state_t                state_q;
  state_t                state_d;
  logic [TABLE_AW-1:0]   ptr_q;
  logic [1:0]            op_q;
  logic [5:0]            arg_q;
  logic                  phase_q;
  logic [3:0]            rep_q;
  logic [WC_W-1:0]       wcnt_q;
  logic [TO_W-1:0]       tocnt_q;
  logic [1:0]            addr_q;
  logic [7:0]            wdata_q;

  logic more_writes;
  logic ptr_last;
  logic to_hit;
  logic rerun_go;
  logic ack_lo_exit;
  logic advance;

  // Second byte of a register write: VDP "write register" marker plus index.
  function automatic logic [7:0] reg_select_byte(input logic [5:0] arg);
    return {2'b10, arg};
  endfunction

  function automatic logic [WC_W-1:0] wait_cycles(input logic [7:0] data);
    return WC_W'(data) << WAIT_SHIFT;
  endfunction

  assign more_writes = ((op_q == OP_REG) && !phase_q) || ((op_q == OP_PORT) && (rep_q != 4'd0));
  assign ptr_last    = &ptr_q;
  assign to_hit      = (ACK_TIMEOUT != 0) && (tocnt_q == TO_LAST);
  assign rerun_go    = RERUN && start;
  assign ack_lo_exit = (state_q == S_ACK_LO) && !ack;
  assign advance     = (ack_lo_exit && !more_writes) || ((state_q == S_WAITCNT) && (wcnt_q == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT_WAIT: if (!sdram_busy) state_d = S_IDLE;
      S_IDLE:      if (start) state_d = S_FETCH;
      S_FETCH:     state_d = S_DECODE;
      S_DECODE: begin
        case (tbl_data[15:14])
          OP_END:  state_d = S_DONE;
          OP_WAIT: state_d = S_WAITCNT;
          default: state_d = S_REQ;
        endcase
      end
      S_REQ:       state_d = S_ACK_HI;
      S_ACK_HI: begin
        if (ack)         state_d = S_ACK_LO;
        else if (to_hit) state_d = S_ERROR;
      end
      S_ACK_LO: begin
        if (!ack) begin
          if (more_writes)   state_d = S_REQ;
          else if (ptr_last) state_d = S_DONE;
          else               state_d = S_FETCH;
        end else if (to_hit) begin
          state_d = S_ERROR;
        end
      end
      S_WAITCNT: begin
        if (wcnt_q == '0) state_d = ptr_last ? S_DONE : S_FETCH;
      end
      S_DONE, S_ERROR: if (rerun_go) state_d = S_FETCH;
      default:     state_d = S_INIT_WAIT;
    endcase
  end

  always_comb begin
    req   = (state_q == S_REQ) || (state_q == S_ACK_HI);
    wr    = req;
    busy  = !((state_q == S_INIT_WAIT) || (state_q == S_IDLE) ||
              (state_q == S_DONE) || (state_q == S_ERROR));
    done  = (state_q == S_DONE);
    error = (state_q == S_ERROR);
  end

  // Entry pointer and the bus-visible address/data, both reset to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      addr_q  <= 2'd0;
      wdata_q <= 8'd0;
    end else begin
      if (((state_q == S_IDLE) && start) ||
          (((state_q == S_DONE) || (state_q == S_ERROR)) && rerun_go)) begin
        ptr_q <= '0;
      end else if (advance && !ptr_last) begin
        ptr_q <= ptr_q + TABLE_AW'(1);
      end

      if (state_q == S_DECODE) begin
        if (tbl_data[15:14] == OP_REG) begin
          addr_q  <= 2'd1;
          wdata_q <= tbl_data[7:0];
        end else if (tbl_data[15:14] == OP_PORT) begin
          addr_q  <= tbl_data[9:8];
          wdata_q <= tbl_data[7:0];
        end
      end else if (ack_lo_exit && more_writes && (op_q == OP_REG)) begin
        wdata_q <= reg_select_byte(arg_q);
      end
    end
  end

  // Per-entry working registers; only meaningful after DECODE has loaded them.
  always_ff @(posedge clk) begin
    if (state_q == S_DECODE) begin
      op_q    <= tbl_data[15:14];
      arg_q   <= tbl_data[13:8];
      phase_q <= 1'b0;
      rep_q   <= tbl_data[13:10];
      wcnt_q  <= wait_cycles(tbl_data[7:0]);
    end else begin
      if (ack_lo_exit && more_writes) begin
        if (op_q == OP_REG) phase_q <= 1'b1;
        else                rep_q   <= rep_q - 4'd1;
      end
      if ((state_q == S_WAITCNT) && (wcnt_q != '0)) wcnt_q <= wcnt_q - WC_W'(1);
    end

    if ((state_q == S_REQ) || ((state_q == S_ACK_HI) && ack)) begin
      tocnt_q <= '0;
    end else if ((state_q == S_ACK_HI) || (state_q == S_ACK_LO)) begin
      tocnt_q <= tocnt_q + TO_W'(1);
    end
  end

  assign tbl_addr = ptr_q;
  assign address  = addr_q;
  assign wdata    = wdata_q;

endmodule
